// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
// Optional build macro: SEG_SCAN_LZ_BLANK_EN (leading-zero suppression).
module seg_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [3:0]            encoded,
    output logic [DIGITS-1:0]     anode,
    output logic                  dp_n,
    output logic                  frame_done
);
    localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(DIGIT_CYCLES - 1);

    typedef enum logic [1:0] {OFF, BLANK, DRIVE} state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [4*DIGITS-1:0]   pend_bcd_reg, pend_bcd_next;
    logic [4*DIGITS-1:0]   act_bcd_reg, act_bcd_next;
    logic [DIGITS-1:0]     pend_dp_reg, pend_dp_next;
    logic [DIGITS-1:0]     act_dp_reg, act_dp_next;
    logic                  pend_valid_reg, pend_valid_next;
    logic [3:0]            encoded_reg, encoded_next;
    logic [DIGITS-1:0]     anode_reg, anode_next;
    logic                  dp_n_reg, dp_n_next;
    logic                  frame_done_reg, frame_done_next;
    logic                  copy;
    logic [3:0]            sel_nibble;

    // Next-state, counters and frame buffers
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + 1'b1;
        idx_next        = idx_reg;
        frame_done_next = 1'b0;
        copy            = 1'b0;
        case (state_reg)
            OFF: begin
                cnt_next = '0;
                idx_next = '0;
                if (en) begin
                    state_next = BLANK;
                    copy       = 1'b1;
                end
            end
            BLANK: begin
                if (cnt_reg == BLANK_LAST) begin
                    state_next = DRIVE;
                    cnt_next   = '0;
                end
            end
            DRIVE: begin
                if (cnt_reg == DRIVE_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    if (idx_reg == LAST_IDX) begin
                        idx_next        = '0;
                        copy            = 1'b1;
                        frame_done_next = 1'b1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = OFF;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
        if (!en) begin
            state_next      = OFF;
            cnt_next        = '0;
            idx_next        = '0;
            copy            = 1'b0;
            frame_done_next = 1'b0;
        end

        pend_bcd_next   = pend_bcd_reg;
        pend_dp_next    = pend_dp_reg;
        act_bcd_next    = act_bcd_reg;
        act_dp_next     = act_dp_reg;
        pend_valid_next = pend_valid_reg;
        // The frame copy reads the old pending contents; a same-cycle load lands for the next frame.
        if (copy && pend_valid_reg) begin
            act_bcd_next    = pend_bcd_reg;
            act_dp_next     = pend_dp_reg;
            pend_valid_next = 1'b0;
        end
        if (load) begin
            pend_bcd_next   = bcd_in;
            pend_dp_next    = dp_in;
            pend_valid_next = 1'b1;
        end
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    logic [DIGITS-1:1] zero_dig;
    logic [DIGITS-1:0] lz_mask;
    genvar gi;
    assign lz_mask[0] = 1'b0;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_lz
            assign zero_dig[gi] = (act_bcd_next[4*gi +: 4] == 4'h0);
            assign lz_mask[gi]  = &zero_dig[DIGITS-1:gi];
        end
    endgenerate
`endif

    // Outputs are decoded from next-state values so they register alongside the state.
    always_comb begin
        sel_nibble   = act_bcd_next[{idx_next, 2'b00} +: 4];
        anode_next   = '1;
        encoded_next = 4'hF;
        dp_n_next    = 1'b1;
        if (state_next != OFF) begin
`ifdef SEG_SCAN_LZ_BLANK_EN
            encoded_next = lz_mask[idx_next] ? 4'hF : sel_nibble;
`else
            encoded_next = sel_nibble;
`endif
        end
        if (state_next == DRIVE) begin
            anode_next[idx_next] = 1'b0;
            dp_n_next            = ~act_dp_next[idx_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= OFF;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            pend_bcd_reg   <= '1;
            act_bcd_reg    <= '1;
            pend_dp_reg    <= '0;
            act_dp_reg     <= '0;
            pend_valid_reg <= 1'b0;
            encoded_reg    <= 4'hF;
            anode_reg      <= '1;
            dp_n_reg       <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            pend_bcd_reg   <= pend_bcd_next;
            act_bcd_reg    <= act_bcd_next;
            pend_dp_reg    <= pend_dp_next;
            act_dp_reg     <= act_dp_next;
            pend_valid_reg <= pend_valid_next;
            encoded_reg    <= encoded_next;
            anode_reg      <= anode_next;
            dp_n_reg       <= dp_n_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign encoded    = encoded_reg;
    assign anode      = anode_reg;
    assign dp_n       = dp_n_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus pushes expected digit drives, a monitor pops them.
module tb_seg_scan_ctrl;
    localparam int DIGITS = 4;
    localparam int DC     = 3;
    localparam int BC     = 2;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in  = '0;
    logic [3:0]  encoded;
    logic [3:0]  anode;
    logic        dp_n;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    bit mon_on   = 1'b0;

    typedef struct packed {
        logic [3:0] anode;
        logic [3:0] enc;
        logic       dp_n;
    } exp_t;
    exp_t sb_q[$];

    seg_scan_ctrl #(.DIGITS(DIGITS), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
        .encoded(encoded), .anode(anode), .dp_n(dp_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endtask

    // enc holds the expected encoded nibble per digit (digit 0 in bits 3:0)
    task automatic push_frame(input logic [15:0] enc, input logic [3:0] dp, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.anode = ~(4'b0001 << k);
            e.enc   = enc[4*k +: 4];
            e.dp_n  = ~dp[k];
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_anode(input logic [3:0] a, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = (anode == a);
        end
        chk(name, hit, 1);
    endtask

    task automatic wait_fd(input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = (frame_done == 1'b1);
        end
        chk(name, hit, 1);
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        #1;
        bcd_in = v;
        dp_in  = d;
        load   = 1'b1;
        @(negedge clk);
        #1 load = 1'b0;
    endtask

    // Monitor: timing of drive/blank runs, frame period, and scoreboard pops at each drive start
    initial begin
        logic [3:0] prev_anode = 4'hF;
        logic [3:0] prev_enc   = 4'hF;
        int  run = 0, en_hi = 0, fd_gap = 0;
        bit  fd_valid = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n || !en) begin
                en_hi    = 0;
                fd_valid = 1'b0;
            end else begin
                en_hi++;
            end
            fd_gap++;
            if (frame_done) begin
                if (fd_valid) chk("frame_period", fd_gap, 20);
                fd_valid = rst_n && en;
                fd_gap   = 0;
            end
            if (anode != 4'hF && prev_anode == 4'hF) begin
                if (en_hi >= 6) begin
                    chk("blank_len", run, BC);
                    chk("enc_stable", encoded, prev_enc);
                end
                chk("onehot", $countones(~anode), 1);
                if (mon_on) begin
                    chk("sb_nonempty", (sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk("drive_anode", anode, e.anode);
                        chk("drive_enc", encoded, e.enc);
                        chk("drive_dp", dp_n, e.dp_n);
                    end
                end
                run = 1;
            end else if (anode == 4'hF && prev_anode != 4'hF) begin
                if (en_hi >= 6) chk("drive_len", run, DC);
                run = 1;
            end else begin
                run++;
            end
            prev_anode = anode;
            prev_enc   = encoded;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_anode", anode, 4'hF);
        chk("rst_enc", encoded, 4'hF);
        chk("rst_dp", dp_n, 1);
        chk("rst_fd", frame_done, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rel_blank_anode", anode, 4'hF);
        chk("rel_blank_enc", encoded, 4'hF);
        @(negedge clk);
        chk("rel_first_drive", anode, 4'b1110);
        chk("rel_first_enc", encoded, 4'hF);
        chk("rel_first_dp", dp_n, 1);

        pulse_load(16'h1234, 4'b0001);
        wait_fd("fd_a");
        mon_on = 1'b1;
        push_frame(16'h1234, 4'b0001, 4);
        wait_fd("fd_b");
        push_frame(16'h1234, 4'b0001, 4);
        // Load mid-frame: digits 2 and 3 of this frame must keep the old value
        wait_anode(4'b1011, "w_tear");
        pulse_load(16'h5678, 4'b0000);
        wait_fd("fd_c");
        push_frame(16'h5678, 4'b0000, 4);

        wait_anode(4'b1101, "w_c1");
        pulse_load(16'h4321, 4'b1000);
        // Load exactly on the posedge that enters BLANK for digit 0
        wait_anode(4'b0111, "w_c3");
        @(negedge clk);
        @(negedge clk);
        #1;
        bcd_in = 16'h9999;
        dp_in  = 4'b0000;
        load   = 1'b1;
        @(negedge clk);
        chk("boundary_fd", frame_done, 1);
        push_frame(16'h4321, 4'b1000, 4);
        #1 load = 1'b0;
        wait_fd("fd_e");
        push_frame(16'h9999, 4'b0000, 3);

        wait_anode(4'b1011, "w_e2");
        #1 en = 1'b0;
        @(negedge clk);
        chk("endrop_anode", anode, 4'hF);
        chk("endrop_enc", encoded, 4'hF);
        chk("endrop_dp", dp_n, 1);
        repeat (4) @(negedge clk);
        chk("off_hold", anode, 4'hF);
        push_frame(16'h9999, 4'b0000, 4);
        #1 en = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (anode == 4'hF && lat < 50);
        chk("restart_lat", lat, 1 + BC);
        chk("restart_anode", anode, 4'b1110);

        pulse_load(16'h0070, 4'b0000);
        wait_fd("fd_g");
`ifdef SEG_SCAN_LZ_BLANK_EN
        push_frame(16'hFF70, 4'b0000, 4);
`else
        push_frame(16'h0070, 4'b0000, 4);
`endif
        wait_anode(4'b1101, "w_g1");
        pulse_load(16'h0000, 4'b0000);
        wait_fd("fd_h");
`ifdef SEG_SCAN_LZ_BLANK_EN
        push_frame(16'hFFF0, 4'b0000, 4);
`else
        push_frame(16'h0000, 4'b0000, 4);
`endif
        wait_anode(4'b0111, "w_h3");
        #1 mon_on = 1'b0;
        chk("sb_empty", sb_q.size(), 0);

        // Reset asserted mid-drive must clear outputs without a clock edge
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_anode", anode, 4'hF);
        chk("async_enc", encoded, 4'hF);
        chk("async_dp", dp_n, 1);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
